// File: rtl/snn_pkg.sv
// Shared widths, accumulator limits, controller states and the saturation
// helper for the run_network spiking classifier.
package snn_pkg;

  localparam int WEIGHT_W = 9;
  localparam int BAL_W    = 11;
  localparam int SUM_W    = 12;

  localparam logic signed [BAL_W-1:0] BAL_MAX = 11'sh3FF;
  localparam logic signed [BAL_W-1:0] BAL_MIN = 11'sh400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp a 13-bit signed intermediate into the 11-bit balance range.
  function automatic logic signed [BAL_W-1:0] sat11(input logic signed [BAL_W+1:0] v);
    if (v > 13'sd1023)       return BAL_MAX;
    else if (v < -13'sd1024) return BAL_MIN;
    else                     return v[BAL_W-1:0];
  endfunction

endpackage

// File: rtl/divide_clock.sv
// Step-rate divider: counts enabled clocks 0..DENOM-1 and emits a one-cycle
// enable pulse on the last count. No clock is generated.
module divide_clock #(
  parameter int DENOM = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = (DENOM > 1) ? $clog2(DENOM) : 1;
  localparam logic [DW-1:0] LAST = DW'(DENOM - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_div <= '0;
    end else if (en) begin
      if (r_div == LAST) r_div <= '0;
      else               r_div <= r_div + 1'b1;
    end
  end

  assign tick = en && (r_div == LAST);

endmodule

// File: rtl/run_network.sv
// Single-layer spiking classifier: sums the weights of active pixels into a
// saturating signed balance for WIDTH steps, then fires the sign neuron.
module run_network
  import snn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7,
  parameter int DENOM  = 2,
  parameter logic [HEIGHT*WEIGHT_W-1:0] WEIGHTS =
    {9'd511, 9'd257, 9'd260, 9'd260, 9'd511, 9'd257, 9'd255}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic [HEIGHT-1:0]       pixels,
  output logic [1:0]              neuron_out,
  output logic signed [BAL_W-1:0] balance_out,
  output logic                    done,
  output logic [1:0]              o_dbg_state
);

  localparam int STEP_W = $clog2(WIDTH + 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [STEP_W-1:0]         r_step;
  logic signed [BAL_W-1:0]   r_balance;
  logic [1:0]                r_neuron;
  logic                      r_done;
  logic                      w_div_en;
  logic                      w_tick;
  logic                      w_last;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [BAL_W+1:0]   w_bal_sum;
  logic signed [BAL_W-1:0]   w_bal_next;

  // The divider only advances while a classification is running.
  assign w_div_en = en && (r_state == RUN);

  divide_clock #(.DENOM(DENOM)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (w_div_en),
    .tick (w_tick)
  );

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < HEIGHT; i++) begin
      if (pixels[i]) w_sum = w_sum + SUM_W'($signed(WEIGHTS[i*WEIGHT_W +: WEIGHT_W]));
    end
  end

  assign w_bal_sum  = (BAL_W+2)'(r_balance) + (BAL_W+2)'(w_sum);
  assign w_bal_next = sat11(w_bal_sum);
  assign w_last     = (r_step == STEP_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        RUN:     if (w_tick && w_last) w_state_nxt = DONE;
        DONE:    w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_balance <= '0;
      r_step    <= '0;
      r_neuron  <= 2'b00;
      r_done    <= 1'b0;
    end else if (w_tick) begin
      r_balance <= w_bal_next;
      r_step    <= r_step + 1'b1;
      if (w_last) begin
        r_done <= 1'b1;
        if (w_bal_next > 0)      r_neuron <= 2'b01;
        else if (w_bal_next < 0) r_neuron <= 2'b10;
        else                     r_neuron <= 2'b00;
      end
    end
  end

  assign neuron_out  = r_neuron;
  assign balance_out = r_balance;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_run_network.sv
// Randomised bench for run_network with a step-level reference model.
module tb_run_network;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 7;
  localparam int DENOM  = 2;
  localparam logic [62:0] WEIGHTS =
    {9'd511, 9'd257, 9'd260, 9'd260, 9'd511, 9'd257, 9'd255};

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               start;
  logic [HEIGHT-1:0]  pixels;
  logic [1:0]         neuron_out;
  logic signed [10:0] balance_out;
  logic               done;
  logic [1:0]         dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  run_network dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .pixels      (pixels),
    .neuron_out  (neuron_out),
    .balance_out (balance_out),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int weight(input int i);
    int v;
    v = int'(WEIGHTS[9*i +: 9]);
    if (v >= 256) v = v - 512;
    return v;
  endfunction

  function automatic int col_sum(input logic [HEIGHT-1:0] p);
    int s = 0;
    for (int i = 0; i < HEIGHT; i++) if (p[i]) s += weight(i);
    return s;
  endfunction

  function automatic int clamp(input int v);
    if (v > 1023)  return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  function automatic logic [1:0] cls(input int b);
    if (b > 0) return 2'b01;
    if (b < 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic check_outs(input string tag, input int bal, input logic [1:0] nrn, input logic dn);
    check({tag, "_balance"}, 32'($signed(balance_out)), bal);
    check({tag, "_neuron"}, 32'(neuron_out), 32'(nrn));
    check({tag, "_done"}, 32'(done), 32'(dn));
  endtask

  // Runs one classification from a start pulse; stops early after max_en
  // enabled clocks so callers can interrupt a run.
  task automatic run_class(input logic [HEIGHT-1:0] pix, input bit rand_pix,
                           input bit rand_en, input int max_en, output int bal);
    int en_cnt = 0;
    int ticks  = 0;
    int cyc    = 0;
    bit full;
    full  = (max_en >= WIDTH * DENOM);
    bal   = 0;
    start = 1'b1;
    en    = 1'($urandom_range(0, 1));
    pixels = pix;
    @(posedge clk); #1;
    start = 1'b0;
    check_outs("after_start", 0, 2'b00, 1'b0);
    while (ticks < WIDTH && en_cnt < max_en && cyc < 400) begin
      en     = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      pixels = rand_pix ? HEIGHT'($urandom) : pix;
      if (en) begin
        en_cnt++;
        if (en_cnt % DENOM == 0) begin
          ticks++;
          bal = clamp(bal + col_sum(pixels));
        end
      end
      @(posedge clk); #1;
      cyc++;
      check_outs("step", bal, (ticks == WIDTH) ? cls(bal) : 2'b00, ticks == WIDTH);
    end
    if (full) begin
      check("done_within_budget", 32'(ticks), 32'(WIDTH));
      for (int k = 0; k < 4; k++) begin
        en     = 1'($urandom_range(0, 1));
        pixels = HEIGHT'($urandom);
        @(posedge clk); #1;
        check_outs("done_hold", bal, cls(bal), 1'b1);
      end
    end
  endtask

  initial begin
    int bal;
    rst = 1'b1; en = 1'b0; start = 1'b0; pixels = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 2'b00, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      en     = 1'($urandom_range(0, 1));
      pixels = HEIGHT'($urandom);
      @(posedge clk); #1;
      check_outs("idle", 0, 2'b00, 1'b0);
    end

    run_class(7'b0000111, 0, 0, 1000, bal);
    check("small_neg_final", 32'($signed(balance_out)), -32'sd8);
    check("small_neg_class", 32'(neuron_out), 32'(2'b10));
    run_class(7'b1111111, 0, 0, 1000, bal);
    check("neg_sat_final", 32'($signed(balance_out)), -32'sd1024);
    run_class(7'b0000001, 0, 0, 1000, bal);
    check("pos_sat_final", 32'($signed(balance_out)), 32'sd1023);
    check("pos_sat_class", 32'(neuron_out), 32'(2'b01));
    run_class(7'b0000000, 0, 0, 1000, bal);
    check("zero_class", 32'(neuron_out), 32'(2'b00));

    run_class(7'b0000111, 0, 1, 1000, bal);
    check("gated_en_final", 32'($signed(balance_out)), -32'sd8);
    for (int r = 0; r < 6; r++) run_class(HEIGHT'($urandom), 1, 1, 1000, bal);

    run_class(7'b0000001, 0, 0, 8, bal);
    run_class(HEIGHT'($urandom), 1, 0, 1000, bal);

    run_class(7'b1111111, 0, 0, 6, bal);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outs("mid_run_reset", 0, 2'b00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      en     = 1'b1;
      pixels = HEIGHT'($urandom);
      @(posedge clk); #1;
      check_outs("post_reset_idle", 0, 2'b00, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
